option_feeder: RTL and testbench
================================

# option_feeder

Streaming source for the nonogram `solver`. It holds every candidate option in an on-chip FIFO and presents options to the solver one line at a time: first a line-index word, then that line's options. It consumes the solver's keep/discard verdict per option, recirculates kept options to the FIFO tail, and maintains the per-line and total option counts that the solver reads. It sits between the option generator (load side) and the solver (stream side).

## Interface
- `SIZE`, 11, max board dimension; line count is `2*SIZE`.
- `DEPTH`, 127, FIFO entries; each entry is {line[4:0], option[15:0]}.
- `clk` in 1, sole clock.
- `rst` in 1, synchronous, active-high reset.
- `num_rows` in 4, board rows; sampled in IDLE.
- `num_cols` in 4, board columns; sampled in IDLE.
- `load_valid` in 1, load strobe.
- `load_line` in 5, line of the loaded option. Rows are 0..num_rows-1; columns are num_rows..num_rows+num_cols-1.
- `load_option` in 16, option bit pattern, LSB = cell 0.
- `load_done` in 1, one-cycle pulse after the last load.
- `started` out 1, one-cycle pulse at stream start (drives solver `started`).
- `option` out 16, line-index word {11'b0, line} or option word.
- `option_valid` out 1, `option` is valid this cycle.
- `new_line` out 1, the current word is a line index.
- `verdict_valid` in 1, solver verdict strobe.
- `put_back` in 1, 1 = keep the option (recirculate), 0 = discard it.
- `solved` in 1, solver reports the board solved.
- `unsolvable` in 1, solver reports the board unsolvable.
- `old_options_amnt` out [2*SIZE-1:0][6:0], remaining option count per line.
- `all_options_remaining` out 7, FIFO occupancy.
- `overflow` out 1, sticky: a load arrived while the FIFO was full.
- `done` out 1, streaming has ended; held until reset.

## Operation
- States: IDLE, LOAD, START, EMIT_LINE, EMIT_OPT, WAIT_VERDICT, DONE.
- IDLE → LOAD on the first `load_valid`.
- LOAD: each `load_valid` pushes {load_line, load_option} and increments `old_options_amnt[load_line]`.
  - If `load_line >= num_rows+num_cols`, the load is ignored.
  - If the FIFO is full, the load is dropped and `overflow` is set.
  - Loads must be grouped by line, ascending. Ordering is not checked.
- LOAD + `load_done` → START. If the FIFO is empty at that point, go to DONE instead.
- START (1 cycle): `started`=1 → EMIT_LINE.
- EMIT_LINE (1 cycle): `option`={11'b0, head.line}, `option_valid`=1, `new_line`=1. Record `cur_line` → EMIT_OPT.
- EMIT_OPT (1 cycle): pop the head and hold it in `inflight`. `option`=inflight.option, `option_valid`=1, `new_line`=0 → WAIT_VERDICT.
- WAIT_VERDICT: outputs held at 0 until `verdict_valid`. In the verdict cycle:
  - `put_back`=1: push `inflight` to the tail. Counts are unchanged.
  - `put_back`=0: decrement `old_options_amnt[cur_line]` and `all_options_remaining`.
  - Next state:
    - FIFO empty → DONE.
    - Head line ≠ `cur_line` → EMIT_LINE.
    - Otherwise → EMIT_OPT.
- Line grouping is preserved because recirculated entries reach the tail in pass order. A line whose count reaches 0 is never indexed again.
- Verdict with `put_back`=1 while the FIFO is full cannot occur, because `inflight` freed a slot.
- `solved` or `unsolvable` asserted in any state from START through WAIT_VERDICT → DONE next cycle. The FIFO and counts freeze, and any pending verdict is discarded.
- DONE: `done`=1. All stream outputs are 0. Only `rst` exits.

## Timing
- Reset values:
  - All outputs 0, including all `old_options_amnt` entries, `overflow` and `done`.
  - FIFO empty; state IDLE.
- Load: count visible the cycle after `load_valid`.
- `load_done` → `started` at +1. First line word at +2. First option at +3.
- Verdict at cycle t → next word at t+1. Minimum 2 cycles per option.
- A verdict-driven count or occupancy change is visible at t+1.
- `rst` has priority over everything. Mid-stream it clears the FIFO, counts and state in one cycle.
- `verdict_valid` outside WAIT_VERDICT is ignored.

## Configuration
- `FEEDER_STALL_DETECT_EN`, when defined:
  - The block tracks passes. Pass length is the occupancy latched at the start of each pass.
  - A pass that completes with zero discards drives the `stalled` output port (1 bit, reset 0) and goes to DONE.
- When undefined: no `stalled` port. The block recirculates until the FIFO drains or the solver asserts `solved`/`unsolvable`.

## Test plan
- Load a 2x3 board: line0 {111}; line1 {000}; lines 2,3,4 {110,011} each. → counts [1,1,2,2,2], `all_options_remaining`=8, `started` pulses 1 cycle after `load_done`.
- Stream line0 with verdict `put_back`=0. → Sequence is `new_line` word 0x0000, then option 0x0007. Line-0 count goes to 0 at verdict+1, and line 0 is never re-indexed.
- Line 2: verdict keeps 110 and drops 011. → 110 reappears at the tail. Next pass emits line word 0x0002 followed by only 110, and count[2]=1.
- Fill 127 entries, then load one more. → `overflow`=1, occupancy stays 127.
- Assert `solved` during WAIT_VERDICT. → DONE next cycle, `option_valid` stays 0, counts frozen. A subsequent `rst` zeroes all outputs in one cycle.
- With `FEEDER_STALL_DETECT_EN`: keep every option for a full pass. → `stalled`=1 and `done`=1 one cycle after the last verdict of the pass.

Source files
------------

// File: rtl/option_feeder.sv
// Option FIFO and line-grouped stream source for the nonogram solver.
// Optional build macro FEEDER_STALL_DETECT_EN adds pass tracking and the stalled output.
module option_feeder #(
  parameter int SIZE  = 11,
  parameter int DEPTH = 127
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                num_rows,
  input  logic [3:0]                num_cols,
  input  logic                      load_valid,
  input  logic [4:0]                load_line,
  input  logic [15:0]               load_option,
  input  logic                      load_done,
  output logic                      started,
  output logic [15:0]               option,
  output logic                      option_valid,
  output logic                      new_line,
  input  logic                      verdict_valid,
  input  logic                      put_back,
  input  logic                      solved,
  input  logic                      unsolvable,
  output logic [2*SIZE-1:0][6:0]    old_options_amnt,
  output logic [6:0]                all_options_remaining,
  output logic                      overflow,
  output logic                      done
`ifdef FEEDER_STALL_DETECT_EN
  ,
  output logic                      stalled
`endif
);

  // state        | meaning
  // IDLE         | waiting for first load, board size sampled
  // LOAD         | accepting options until load_done
  // START        | one-cycle started pulse
  // EMIT_LINE    | line-index word on the stream
  // EMIT_OPT     | option word on the stream, entry held in inflight
  // WAIT_VERDICT | waiting for keep/discard
  // DONE         | stream ended, held until rst
  typedef enum logic [2:0] {
    IDLE, LOAD, START, EMIT_LINE, EMIT_OPT, WAIT_VERDICT, DONE
  } state_t;

  localparam int PW = $clog2(DEPTH);

  state_t       state;
  logic [20:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [6:0]   fifo_count;
  logic [3:0]   rows_q, cols_q;
  logic [4:0]   cur_line;
  logic [20:0]  inflight;

  logic [20:0]  head;
  logic [4:0]   head_line;
  logic [4:0]   line_limit;
  logic         full, load_ok, load_push;
  logic         stop, verdict, reuse, drained, go_line, pop, push;
  logic [20:0]  push_data;
  logic         stall_hit;

`ifdef FEEDER_STALL_DETECT_EN
  logic [6:0]   pass_len, pass_cnt;
  logic         pass_disc;
`endif

  assign head      = mem[rd_ptr];
  assign head_line = head[20:16];
  assign full      = (fifo_count == 7'(DEPTH));

  always_comb begin
    line_limit = (state == IDLE) ? ({1'b0, num_rows} + {1'b0, num_cols})
                                 : ({1'b0, rows_q} + {1'b0, cols_q});
    load_ok   = load_valid && (load_line < line_limit) && (load_line < 5'(2*SIZE));
    load_push = (state == IDLE || state == LOAD) && load_ok && !full;
    stop      = solved || unsolvable;
    verdict   = (state == WAIT_VERDICT) && verdict_valid && !stop;
`ifdef FEEDER_STALL_DETECT_EN
    stall_hit = verdict && put_back && !pass_disc && (pass_cnt + 7'd1 == pass_len);
`else
    stall_hit = 1'b0;
`endif
    reuse   = verdict && put_back && (fifo_count == 7'd0) && !stall_hit;
    drained = verdict && !put_back && (fifo_count == 7'd0);
    go_line = verdict && (fifo_count != 7'd0) && (head_line != cur_line) && !stall_hit;
    pop     = ((state == EMIT_LINE) && !stop) ||
              (verdict && (fifo_count != 7'd0) && (head_line == cur_line) && !stall_hit);
    push      = 1'b0;
    push_data = '0;
    if (load_push) begin
      push      = 1'b1;
      push_data = {load_line, load_option};
    end else if (verdict && put_back && (fifo_count != 7'd0)) begin
      // With an empty FIFO the kept entry simply stays in inflight.
      push      = 1'b1;
      push_data = inflight;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      rd_ptr                <= '0;
      wr_ptr                <= '0;
      fifo_count            <= '0;
      rows_q                <= '0;
      cols_q                <= '0;
      cur_line              <= '0;
      inflight              <= '0;
      started               <= 1'b0;
      option                <= '0;
      option_valid          <= 1'b0;
      new_line              <= 1'b0;
      old_options_amnt      <= '0;
      all_options_remaining <= '0;
      overflow              <= 1'b0;
      done                  <= 1'b0;
`ifdef FEEDER_STALL_DETECT_EN
      stalled               <= 1'b0;
      pass_len              <= '0;
      pass_cnt              <= '0;
      pass_disc             <= 1'b0;
`endif
    end else begin
      started      <= 1'b0;
      option       <= '0;
      option_valid <= 1'b0;
      new_line     <= 1'b0;

      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
      fifo_count <= fifo_count + 7'(push) - 7'(pop);

      if (load_push) begin
        old_options_amnt[load_line] <= old_options_amnt[load_line] + 7'd1;
        all_options_remaining       <= all_options_remaining + 7'd1;
      end
      if ((state == IDLE || state == LOAD) && load_ok && full) overflow <= 1'b1;

      case (state)
        IDLE: begin
          rows_q <= num_rows;
          cols_q <= num_cols;
          if (load_valid) state <= LOAD;
        end
        LOAD: begin
          if (load_done) begin
            if (fifo_count == 7'd0 && !load_push) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= START;
              started <= 1'b1;
            end
          end
        end
        START: begin
`ifdef FEEDER_STALL_DETECT_EN
          pass_len  <= all_options_remaining;
          pass_cnt  <= '0;
          pass_disc <= 1'b0;
`endif
          if (stop) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state        <= EMIT_LINE;
            option       <= {11'b0, head_line};
            option_valid <= 1'b1;
            new_line     <= 1'b1;
            cur_line     <= head_line;
          end
        end
        EMIT_LINE: begin
          if (stop) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state        <= EMIT_OPT;
            inflight     <= head;
            option       <= head[15:0];
            option_valid <= 1'b1;
          end
        end
        EMIT_OPT: begin
          if (stop) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= WAIT_VERDICT;
          end
        end
        WAIT_VERDICT: begin
          if (stop) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (verdict_valid) begin
            if (!put_back) begin
              old_options_amnt[cur_line] <= old_options_amnt[cur_line] - 7'd1;
              all_options_remaining      <= all_options_remaining - 7'd1;
            end
`ifdef FEEDER_STALL_DETECT_EN
            if (pass_cnt + 7'd1 == pass_len) begin
              pass_len  <= all_options_remaining - 7'(!put_back);
              pass_cnt  <= '0;
              pass_disc <= 1'b0;
            end else begin
              pass_cnt  <= pass_cnt + 7'd1;
              pass_disc <= pass_disc | !put_back;
            end
            if (stall_hit) stalled <= 1'b1;
`endif
            if (stall_hit || drained) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (reuse) begin
              state        <= EMIT_OPT;
              option       <= inflight[15:0];
              option_valid <= 1'b1;
            end else if (go_line) begin
              state        <= EMIT_LINE;
              option       <= {11'b0, head_line};
              option_valid <= 1'b1;
              new_line     <= 1'b1;
              cur_line     <= head_line;
            end else begin
              state        <= EMIT_OPT;
              inflight     <= head;
              option       <= head[15:0];
              option_valid <= 1'b1;
            end
          end
        end
        DONE: done <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_option_feeder.sv
// Directed bench for option_feeder: load, stream, recirculation, overflow, solved, reset.
module tb_option_feeder;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        num_rows, num_cols;
  logic              load_valid;
  logic [4:0]        load_line;
  logic [15:0]       load_option;
  logic              load_done;
  logic              started;
  logic [15:0]       option;
  logic              option_valid, new_line;
  logic              verdict_valid, put_back, solved, unsolvable;
  logic [21:0][6:0]  old_options_amnt;
  logic [6:0]        all_options_remaining;
  logic              overflow, done;
`ifdef FEEDER_STALL_DETECT_EN
  logic              stalled;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  option_feeder dut (
    .clk(clk), .rst(rst), .num_rows(num_rows), .num_cols(num_cols),
    .load_valid(load_valid), .load_line(load_line), .load_option(load_option),
    .load_done(load_done), .started(started), .option(option),
    .option_valid(option_valid), .new_line(new_line),
    .verdict_valid(verdict_valid), .put_back(put_back), .solved(solved),
    .unsolvable(unsolvable), .old_options_amnt(old_options_amnt),
    .all_options_remaining(all_options_remaining), .overflow(overflow), .done(done)
`ifdef FEEDER_STALL_DETECT_EN
    , .stalled(stalled)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [4:0] ln, input logic [15:0] op);
    load_valid  = 1'b1;
    load_line   = ln;
    load_option = op;
    tick();
    load_valid  = 1'b0;
  endtask

  // Checks optional line word, then the option word, then issues a verdict.
  task automatic step_opt(input logic lw, input logic [4:0] ln, input logic [15:0] op,
                          input logic pb);
    if (lw) begin
      check("line_word", {14'b0, option_valid, new_line, option}, {14'b0, 2'b11, 11'b0, ln});
      tick();
    end
    check("opt_word", {14'b0, option_valid, new_line, option}, {14'b0, 2'b10, op});
    tick();
    check("wait_quiet", {31'b0, option_valid}, 32'd0);
    verdict_valid = 1'b1;
    put_back      = pb;
    tick();
    verdict_valid = 1'b0;
    put_back      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [6:0] exp_cnt [5];
    rst = 1'b1; num_rows = 4'd2; num_cols = 4'd3;
    load_valid = 1'b0; load_line = '0; load_option = '0; load_done = 1'b0;
    verdict_valid = 1'b0; put_back = 1'b0; solved = 1'b0; unsolvable = 1'b0;
    do_reset();
    check("rst_amnt", {31'b0, |old_options_amnt}, 32'd0);
    check("rst_total", {25'b0, all_options_remaining}, 32'd0);
    check("rst_outs", {27'b0, started, option_valid, new_line, overflow, done}, 32'd0);

    // 2x3 board
    load(5'd0, 16'h0007);
    check("load_cnt_next", {25'b0, old_options_amnt[0]}, 32'd1);
    load(5'd1, 16'h0000);
    for (int l = 2; l < 5; l++) begin
      load(5'(l), 16'h0006);
      load(5'(l), 16'h0003);
    end
    load(5'd5, 16'h00ff);
    check("ignored_line", {25'b0, all_options_remaining}, 32'd8);
    exp_cnt = '{7'd1, 7'd1, 7'd2, 7'd2, 7'd2};
    for (int i = 0; i < 5; i++) check("load_cnt", {25'b0, old_options_amnt[i]}, {25'b0, exp_cnt[i]});
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    check("started", {31'b0, started}, 32'd1);
    tick();
    check("started_pulse", {31'b0, started}, 32'd0);

    // pass 1
    step_opt(1'b1, 5'd0, 16'h0007, 1'b0);
    check("line0_cnt", {25'b0, old_options_amnt[0]}, 32'd0);
    check("total_7", {25'b0, all_options_remaining}, 32'd7);
    step_opt(1'b1, 5'd1, 16'h0000, 1'b1);
    step_opt(1'b1, 5'd2, 16'h0006, 1'b1);
    step_opt(1'b0, 5'd2, 16'h0003, 1'b0);
    check("line2_cnt", {25'b0, old_options_amnt[2]}, 32'd1);
    step_opt(1'b1, 5'd3, 16'h0006, 1'b1);
    step_opt(1'b0, 5'd3, 16'h0003, 1'b1);
    step_opt(1'b1, 5'd4, 16'h0006, 1'b1);
    step_opt(1'b0, 5'd4, 16'h0003, 1'b1);
    check("total_6", {25'b0, all_options_remaining}, 32'd6);

    // pass 2: line 0 skipped, line 2 only has 110
    step_opt(1'b1, 5'd1, 16'h0000, 1'b1);
    step_opt(1'b1, 5'd2, 16'h0006, 1'b1);
    check("line_word3", {14'b0, option_valid, new_line, option}, {14'b0, 2'b11, 16'h0003});
    tick();
    check("opt3_word", {14'b0, option_valid, new_line, option}, {14'b0, 2'b10, 16'h0006});
    tick();
    solved = 1'b1;
    tick();
    solved = 1'b0;
    check("solved_done", {31'b0, done}, 32'd1);
    check("solved_quiet", {31'b0, option_valid}, 32'd0);
    check("frozen_cnt3", {25'b0, old_options_amnt[3]}, 32'd2);
    check("frozen_total", {25'b0, all_options_remaining}, 32'd6);
    verdict_valid = 1'b1;
    put_back      = 1'b0;
    tick();
    verdict_valid = 1'b0;
    tick();
    check("done_ignore_verdict", {25'b0, all_options_remaining}, 32'd6);
    check("done_held", {30'b0, done, option_valid}, 32'd2);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_amnt", {31'b0, |old_options_amnt}, 32'd0);
    check("midrst_total", {25'b0, all_options_remaining}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);

    // overflow
    num_rows = 4'd11; num_cols = 4'd11;
    for (int i = 0; i < 127; i++) load(5'd0, 16'(i));
    check("full_no_ovf", {31'b0, overflow}, 32'd0);
    check("full_total", {25'b0, all_options_remaining}, 32'd127);
    load(5'd0, 16'hbeef);
    check("ovf_set", {31'b0, overflow}, 32'd1);
    check("ovf_total", {25'b0, all_options_remaining}, 32'd127);
    check("ovf_cnt0", {25'b0, old_options_amnt[0]}, 32'd127);
    do_reset();
    check("ovf_cleared", {31'b0, overflow}, 32'd0);

    // empty FIFO at load_done goes straight to DONE
    num_rows = 4'd2; num_cols = 4'd3;
    load(5'd7, 16'h0001);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    check("empty_done", {30'b0, started, done}, 32'd1);

`ifdef FEEDER_STALL_DETECT_EN
    do_reset();
    num_rows = 4'd1; num_cols = 4'd1;
    load(5'd0, 16'h0001);
    load(5'd1, 16'h0002);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    check("stall_started", {31'b0, started}, 32'd1);
    tick();
    step_opt(1'b1, 5'd0, 16'h0001, 1'b1);
    check("no_stall_yet", {31'b0, stalled}, 32'd0);
    step_opt(1'b1, 5'd1, 16'h0002, 1'b1);
    check("stalled", {30'b0, stalled, done}, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
